sort4_collector: RTL and testbench

//   Upstream feeder for the 4-lane combinational sorter.
//   - Accepts a serial stream of DW-bit samples (valid/ready).
//   - Packs each consecutive group of 4 samples into one 4*DW word; lane 0 holds the first sample.
//   - Presents the word on a registered valid/ready output that drives the sorter's inp bus.
//   - Double-buffered: the next group collects while the previous output word is held.

---
 rtl/sort4_collector_if.sv | 17 +
 rtl/sort4_collector.sv | 97 +++++++++
 tb/tb_sort4_collector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sort4_collector_if.sv
// sort4_collector_if: sample-in / packed-word-out handshake bundle for sort4_collector.
// COLLECT_FLUSH_EN adds the flush request and m_fill count.
interface sort4_collector_if #(parameter int DW = 8);
  logic [DW-1:0] s_data;
  logic s_valid, s_ready;
  logic [4*DW-1:0] m_data;
  logic m_valid, m_ready;
`ifdef COLLECT_FLUSH_EN
  logic flush;
  logic [2:0] m_fill;
  modport master (output s_data, s_valid, m_ready, flush, input s_ready, m_data, m_valid, m_fill);
  modport slave (input s_data, s_valid, m_ready, flush, output s_ready, m_data, m_valid, m_fill);
`else
  modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid);
  modport slave (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
`endif
endinterface

// File: rtl/sort4_collector.sv
// sort4_collector: packs 4 serial samples into one double-buffered 4*DW output word.
// COLLECT_FLUSH_EN enables flushing a partial group padded with all-ones lanes.
module sort4_collector #(parameter int DW = 8) (
  input logic clk,
  input logic rst,
  sort4_collector_if.slave bus
);
  logic [2:0][DW-1:0] acc_q, acc_d;
  logic [DW-1:0] acc3_q, acc3_d;
  logic [1:0] idx_q, idx_d;
  logic acc_full_q, acc_full_d, m_valid_q, m_valid_d;
  logic [4*DW-1:0] m_data_q, m_data_d;
  logic [2:0] cnt;
  logic [3:0][DW-1:0] nl, word;
  logic accept, out_free, fire, flush_w;
`ifdef COLLECT_FLUSH_EN
  logic [2:0] fill_q, fill_d, m_fill_q, m_fill_d;
  assign flush_w = bus.flush;
  assign bus.m_fill = m_fill_q;
`else
  assign flush_w = 1'b0;
`endif
  assign bus.s_ready = !rst && !acc_full_q;
  assign bus.m_data = m_data_q;
  assign bus.m_valid = m_valid_q;
  // A held group is stored already padded, so only its fill count needs remembering.
  always_comb begin
    accept = bus.s_valid && bus.s_ready;
    out_free = !m_valid_q || bus.m_ready;
    cnt = {1'b0, idx_q} + {2'b0, accept};
    nl = {bus.s_data, acc_q};
    if (accept) nl[idx_q] = bus.s_data;
    for (int i = 0; i < 4; i++) word[i] = (3'(i) < cnt) ? nl[i] : {DW{1'b1}};
    fire = (accept && idx_q == 2'd3) || (flush_w && cnt != 3'd0 && !acc_full_q);
    acc_d = acc_q;
    acc3_d = acc3_q;
    idx_d = idx_q;
    acc_full_d = acc_full_q;
    m_data_d = m_data_q;
    m_valid_d = m_valid_q && !bus.m_ready;
`ifdef COLLECT_FLUSH_EN
    fill_d = fill_q;
    m_fill_d = m_fill_q;
`endif
    if (acc_full_q && out_free) begin
      m_data_d = {acc3_q, acc_q};
      m_valid_d = 1'b1;
      acc_full_d = 1'b0;
`ifdef COLLECT_FLUSH_EN
      m_fill_d = fill_q;
`endif
    end else if (fire && out_free) begin
      m_data_d = word;
      m_valid_d = 1'b1;
      idx_d = 2'd0;
`ifdef COLLECT_FLUSH_EN
      m_fill_d = cnt;
`endif
    end else if (fire) begin
      acc_d = word[2:0];
      acc3_d = word[3];
      acc_full_d = 1'b1;
      idx_d = 2'd0;
`ifdef COLLECT_FLUSH_EN
      fill_d = cnt;
`endif
    end else if (accept) begin
      acc_d[idx_q] = bus.s_data;
      idx_d = idx_q + 2'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      acc3_q <= '0;
      idx_q <= '0;
      acc_full_q <= 1'b0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
`ifdef COLLECT_FLUSH_EN
      fill_q <= '0;
      m_fill_q <= '0;
`endif
    end else begin
      acc_q <= acc_d;
      acc3_q <= acc3_d;
      idx_q <= idx_d;
      acc_full_q <= acc_full_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
`ifdef COLLECT_FLUSH_EN
      fill_q <= fill_d;
      m_fill_q <= m_fill_d;
`endif
    end
  end
endmodule

// File: tb/tb_sort4_collector.sv
// tb_sort4_collector: directed checks plus a random scoreboard run for sort4_collector.
module tb_sort4_collector;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic [31:0] build;
  int bcnt = 0;
  int n_acc = 0;
  sort4_collector_if #(.DW(DW)) bus ();
  sort4_collector #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic feed(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data = d;
    chk("s_ready_feed", 64'(bus.s_ready), 64'd1);
    tick();
  endtask
  task automatic observe();
    logic [31:0] e;
    if (bus.m_valid && bus.m_ready) begin
      e = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
      chk("rand_word", 64'(bus.m_data), 64'(e));
    end
    if (bus.s_valid && bus.s_ready) begin
      build[bcnt*8 +: 8] = bus.s_data;
      bcnt++;
      n_acc++;
      if (bcnt == 4) begin
        q.push_back(build);
        bcnt = 0;
      end
    end
  endtask
  initial begin
    logic prev_hold;
    logic [31:0] prev_data;
    int cyc;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
`ifdef COLLECT_FLUSH_EN
    bus.flush = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
    bus.m_ready = 1'b1;
    feed(8'h10); feed(8'h20); feed(8'h30); feed(8'h40);
    bus.s_valid = 1'b0;
    chk("t2_valid", 64'(bus.m_valid), 64'd1);
    chk("t2_data", 64'(bus.m_data), 64'h40302010);
`ifdef COLLECT_FLUSH_EN
    chk("t2_fill", 64'(bus.m_fill), 64'd4);
`endif
    tick();
    chk("t2_valid_drop", 64'(bus.m_valid), 64'd0);
    chk("t2_data_kept", 64'(bus.m_data), 64'h40302010);
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) feed(8'(i));
    bus.s_valid = 1'b0;
    chk("t3_valid", 64'(bus.m_valid), 64'd1);
    chk("t3_held", 64'(bus.m_data), 64'h04030201);
    chk("t3_s_ready_low", 64'(bus.s_ready), 64'd0);
    tick();
    chk("t3_still_held", 64'(bus.m_data), 64'h04030201);
    bus.m_ready = 1'b1;
    tick();
    chk("t3_second", 64'(bus.m_data), 64'h08070605);
    chk("t3_second_valid", 64'(bus.m_valid), 64'd1);
    chk("t3_s_ready_back", 64'(bus.s_ready), 64'd1);
    tick();
    chk("t3_empty", 64'(bus.m_valid), 64'd0);
    feed(8'h11); feed(8'h22);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_s_ready", 64'(bus.s_ready), 64'd0);
    tick();
    chk("t5_rst_valid", 64'(bus.m_valid), 64'd0);
    rst = 1'b0;
    tick();
    feed(8'hA1); feed(8'hA2); feed(8'hA3); feed(8'hA4);
    bus.s_valid = 1'b0;
    chk("t5_data", 64'(bus.m_data), 64'hA4A3A2A1);
    chk("t5_valid", 64'(bus.m_valid), 64'd1);
    tick();
    chk("t5_single", 64'(bus.m_valid), 64'd0);
`ifdef COLLECT_FLUSH_EN
    feed(8'h05); feed(8'h07);
    bus.s_valid = 1'b0;
    chk("t4_no_early", 64'(bus.m_valid), 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t4_valid", 64'(bus.m_valid), 64'd1);
    chk("t4_data", 64'(bus.m_data), 64'hFFFF0705);
    chk("t4_fill", 64'(bus.m_fill), 64'd2);
    bus.flush = 1'b1;
    tick();
    chk("t4_idle_flush", 64'(bus.m_valid), 64'd0);
    bus.s_valid = 1'b1;
    bus.s_data = 8'h09;
    tick();
    bus.s_valid = 1'b0;
    bus.flush = 1'b0;
    chk("t4_same_edge", 64'(bus.m_data), 64'hFFFFFF09);
    chk("t4_same_fill", 64'(bus.m_fill), 64'd1);
    tick();
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    prev_hold = 1'b0;
    prev_data = '0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data = 8'($urandom);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_hold) chk("hold_stable", {31'd0, bus.m_valid, bus.m_data}, {31'd0, 1'b1, prev_data});
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      observe();
      tick();
      cyc++;
    end
    chk("rand_count", 64'(n_acc), 64'd1000);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      observe();
      tick();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
